// File: rtl/mips_mc_controller.sv
// -----------------------------------------------------------------------------
// mips_mc_controller
//
// Control unit for a multicycle MIPS datapath that shares one memory port
// between instruction fetch and data access. It is a Moore FSM plus an ALU
// decoder. Every datapath mux select and write enable comes from this block.
// A memready handshake lets the shared memory take several cycles per access.
//
// Optional feature: define MIPS_MC_BNE_EN to add bne (opcode 000101) through
// the extra state BNE (12). Without the macro, bne is an illegal opcode.
//
// Parameters:
//   RESET_STATE  state encoding loaded on reset (FETCH = 0)
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset (0 = in reset)
//   op          in   [5:0] instr[31:26] from the instruction register
//   funct       in   [5:0] instr[5:0]
//   zero        in   ALU zero flag
//   memready    in   memory access completes this cycle
//   memtoreg    out  register write data from memory
//   regdst      out  destination register is rd
//   iord        out  memory address from ALUOut
//   alusrca     out  ALU A operand from register A
//   alusrcb     out  [1:0] 00 B, 01 const 4, 10 signimm, 11 signimm<<2
//   pcsrc       out  [1:0] 00 ALUResult, 01 ALUOut, 10 jump target
//   alucontrol  out  [2:0] ALU function
//   irwrite     out  instruction register write enable
//   memwrite    out  memory write enable
//   regwrite    out  register file write enable
//   pcen        out  PC write enable
//   illegal     out  one-cycle pulse in DECODE on an unknown opcode
//   state       out  [3:0] current FSM state (debug)
// -----------------------------------------------------------------------------
module mips_mc_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       memtoreg,
  output logic       regdst,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_BNE      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_t     r_state;
  state_t     w_next;
  logic       w_memtoreg;
  logic       w_regdst;
  logic       w_iord;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_pcsrc;
  logic [1:0] w_aluop;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_branch_ne;
  logic       w_illegal;

  // Maps aluop/funct to the 3-bit ALU function; unknown encodings fall back to add.
  function automatic logic [2:0] alu_decode(input logic [1:0] aluop,
                                            input logic [5:0] fn);
    logic [2:0] res;
    case (aluop)
      2'b00: res = 3'b010;
      2'b01: res = 3'b110;
      2'b10: begin
        case (fn)
          6'b100000: res = 3'b010;
          6'b100010: res = 3'b110;
          6'b100100: res = 3'b000;
          6'b100101: res = 3'b001;
          6'b101010: res = 3'b111;
          default:   res = 3'b010;
        endcase
      end
      default: res = 3'b010;
    endcase
    return res;
  endfunction

  // State register; reset clears it asynchronously so FETCH shows immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= state_t'(RESET_STATE);
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and raw Moore control decode for the current state.
  always_comb begin
    w_next      = S_FETCH;
    w_memtoreg  = 1'b0;
    w_regdst    = 1'b0;
    w_iord      = 1'b0;
    w_alusrca   = 1'b0;
    w_alusrcb   = 2'b00;
    w_pcsrc     = 2'b00;
    w_aluop     = 2'b00;
    w_irwrite   = 1'b0;
    w_memwrite  = 1'b0;
    w_regwrite  = 1'b0;
    w_pcwrite   = 1'b0;
    w_branch    = 1'b0;
    w_branch_ne = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        // IR and PC+4 are only captured once the fetch read actually completes.
        w_alusrcb = 2'b01;
        w_irwrite = memready;
        w_pcwrite = memready;
        w_next    = memready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEXEC;
          OP_J:         w_next = S_JUMP;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       w_next = S_BNE;
`endif
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = memready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        // Write strobe stays up for the whole wait so the memory sees a stable request.
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        w_next     = memready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b01;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
        w_next    = S_FETCH;
      end
      S_ADDIEXEC: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH;
      end
`ifdef MIPS_MC_BNE_EN
      S_BNE: begin
        // Same datapath setup as BRANCH; only the taken condition is inverted.
        w_alusrca   = 1'b1;
        w_aluop     = 2'b01;
        w_pcsrc     = 2'b01;
        w_branch_ne = 1'b1;
        w_next      = S_FETCH;
      end
`endif
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Output stage: while reset is held, every enable and select is forced safe.
  always_comb begin
    if (!reset) begin
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      iord       = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = 3'b010;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      pcen       = 1'b0;
      illegal    = 1'b0;
    end else begin
      memtoreg   = w_memtoreg;
      regdst     = w_regdst;
      iord       = w_iord;
      alusrca    = w_alusrca;
      alusrcb    = w_alusrcb;
      pcsrc      = w_pcsrc;
      alucontrol = alu_decode(w_aluop, funct);
      irwrite    = w_irwrite;
      memwrite   = w_memwrite;
      regwrite   = w_regwrite;
      pcen       = w_pcwrite | (w_branch & zero) | (w_branch_ne & ~zero);
      illegal    = w_illegal;
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_mips_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mips_mc_controller
//
// Directed, self-checking bench for mips_mc_controller. Inputs change 1 time
// unit after a rising edge. Outputs are checked 1 time unit after that, well
// before the next edge. Expected values are hand-derived from the control
// table. The bne checks follow the MIPS_MC_BNE_EN macro.
// -----------------------------------------------------------------------------
module tb_mips_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       memtoreg;
  logic       regdst;
  logic       iord;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       pcen;
  logic       illegal;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  mips_mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memready   (memready),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .iord       (iord),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .pcen       (pcen),
    .illegal    (illegal),
    .state      (state)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Time limit so the run always ends even if the sequence stalls.
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "time limit reached");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle inputs just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From FETCH with memready=1, present op and move into DECODE.
  task automatic to_decode(input logic [5:0] opc);
    op = opc;
    memready = 1'b1;
    #1;
    chk("fetch_state", {4'd0, state}, 8'd0);
    chk("fetch_irwrite", {7'd0, irwrite}, 8'd1);
    chk("fetch_pcen", {7'd0, pcen}, 8'd1);
    tick();
    chk("decode_state", {4'd0, state}, 8'd1);
    chk("decode_alusrcb", {6'd0, alusrcb}, 8'd3);
  endtask

  initial begin
    reset = 1'b0;
    op = 6'b000000;
    funct = 6'b100000;
    zero = 1'b0;
    memready = 1'b1;
    #2;
    // Reset held: safe outputs even with memready high.
    chk("rst_state", {4'd0, state}, 8'd0);
    chk("rst_irwrite", {7'd0, irwrite}, 8'd0);
    chk("rst_pcen", {7'd0, pcen}, 8'd0);
    chk("rst_alusrcb", {6'd0, alusrcb}, 8'd0);
    chk("rst_alucontrol", {5'd0, alucontrol}, 8'd2);
    tick();
    tick();
    reset = 1'b1;

    // sw, then drop reset in the middle of MEMWR.
    to_decode(6'b101011);
    tick();
    chk("sw_memadr_state", {4'd0, state}, 8'd2);
    chk("sw_memadr_alusrca", {7'd0, alusrca}, 8'd1);
    chk("sw_memadr_alusrcb", {6'd0, alusrcb}, 8'd2);
    tick();
    memready = 1'b0;
    #1;
    chk("sw_memwr_state", {4'd0, state}, 8'd5);
    chk("sw_memwr_memwrite", {7'd0, memwrite}, 8'd1);
    chk("sw_memwr_iord", {7'd0, iord}, 8'd1);
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_memwrite", {7'd0, memwrite}, 8'd0);
    chk("midrst_state", {4'd0, state}, 8'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("rel_state", {4'd0, state}, 8'd0);
    chk("rel_irwrite_wait", {7'd0, irwrite}, 8'd0);
    chk("rel_pcen_wait", {7'd0, pcen}, 8'd0);
    chk("rel_alusrcb", {6'd0, alusrcb}, 8'd1);
    tick();
    chk("fetch_hold_state", {4'd0, state}, 8'd0);

    // lw with memready high throughout: 0,1,2,3,4 then back to 0.
    to_decode(6'b100011);
    tick();
    chk("lw_memadr", {4'd0, state}, 8'd2);
    tick();
    chk("lw_memrd", {4'd0, state}, 8'd3);
    chk("lw_memrd_iord", {7'd0, iord}, 8'd1);
    tick();
    chk("lw_memwb", {4'd0, state}, 8'd4);
    chk("lw_memwb_regwrite", {7'd0, regwrite}, 8'd1);
    chk("lw_memwb_memtoreg", {7'd0, memtoreg}, 8'd1);
    chk("lw_memwb_memwrite", {7'd0, memwrite}, 8'd0);
    tick();
    chk("lw_done", {4'd0, state}, 8'd0);

    // R-type slt.
    funct = 6'b101010;
    to_decode(6'b000000);
    tick();
    chk("slt_exec_state", {4'd0, state}, 8'd6);
    chk("slt_alucontrol", {5'd0, alucontrol}, 8'd7);
    chk("slt_alusrca", {7'd0, alusrca}, 8'd1);
    tick();
    chk("slt_aluwb_state", {4'd0, state}, 8'd7);
    chk("slt_regdst", {7'd0, regdst}, 8'd1);
    chk("slt_regwrite", {7'd0, regwrite}, 8'd1);
    tick();
    chk("slt_done", {4'd0, state}, 8'd0);

    // R-type and, then or, sub and unknown funct decoded in EXECUTE.
    funct = 6'b100100;
    to_decode(6'b000000);
    tick();
    chk("and_alucontrol", {5'd0, alucontrol}, 8'd0);
    funct = 6'b100101;
    #1;
    chk("or_alucontrol", {5'd0, alucontrol}, 8'd1);
    funct = 6'b100010;
    #1;
    chk("sub_alucontrol", {5'd0, alucontrol}, 8'd6);
    funct = 6'b111111;
    #1;
    chk("unk_funct_alucontrol", {5'd0, alucontrol}, 8'd2);
    tick();
    tick();
    chk("and_done", {4'd0, state}, 8'd0);

    // sw with memready low 3 cycles in MEMWR: memwrite held for 4 cycles.
    to_decode(6'b101011);
    chk("sw_decode_regwrite", {7'd0, regwrite}, 8'd0);
    tick();
    chk("sw_memadr_regwrite", {7'd0, regwrite}, 8'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      memready = (i == 3) ? 1'b1 : 1'b0;
      #1;
      chk("sw_wait_state", {4'd0, state}, 8'd5);
      chk("sw_wait_memwrite", {7'd0, memwrite}, 8'd1);
      chk("sw_wait_regwrite", {7'd0, regwrite}, 8'd0);
      tick();
    end
    chk("sw_done", {4'd0, state}, 8'd0);

    // beq taken.
    zero = 1'b1;
    to_decode(6'b000100);
    tick();
    chk("beq_state", {4'd0, state}, 8'd8);
    chk("beq_t_pcen", {7'd0, pcen}, 8'd1);
    chk("beq_pcsrc", {6'd0, pcsrc}, 8'd1);
    chk("beq_alucontrol", {5'd0, alucontrol}, 8'd6);
    tick();
    chk("beq_done", {4'd0, state}, 8'd0);

    // beq not taken.
    zero = 1'b0;
    to_decode(6'b000100);
    tick();
    chk("beq_nt_pcen", {7'd0, pcen}, 8'd0);
    tick();

    // j.
    to_decode(6'b000010);
    tick();
    chk("j_state", {4'd0, state}, 8'd11);
    chk("j_pcsrc", {6'd0, pcsrc}, 8'd2);
    chk("j_pcen", {7'd0, pcen}, 8'd1);
    tick();
    chk("j_done", {4'd0, state}, 8'd0);

    // addi.
    to_decode(6'b001000);
    tick();
    chk("addi_exec_state", {4'd0, state}, 8'd9);
    chk("addi_alusrcb", {6'd0, alusrcb}, 8'd2);
    tick();
    chk("addi_wb_state", {4'd0, state}, 8'd10);
    chk("addi_wb_regwrite", {7'd0, regwrite}, 8'd1);
    chk("addi_wb_regdst", {7'd0, regdst}, 8'd0);
    tick();
    chk("addi_done", {4'd0, state}, 8'd0);

    // Illegal opcode: one-cycle pulse in DECODE, then FETCH.
    op = 6'b111111;
    #1;
    chk("illegal_fetch", {7'd0, illegal}, 8'd0);
    to_decode(6'b111111);
    chk("illegal_decode", {7'd0, illegal}, 8'd1);
    tick();
    chk("illegal_next_state", {4'd0, state}, 8'd0);
    chk("illegal_cleared", {7'd0, illegal}, 8'd0);

    // bne.
    zero = 1'b0;
    to_decode(6'b000101);
`ifdef MIPS_MC_BNE_EN
    chk("bne_illegal", {7'd0, illegal}, 8'd0);
    tick();
    chk("bne_state", {4'd0, state}, 8'd12);
    chk("bne_t_pcen", {7'd0, pcen}, 8'd1);
    chk("bne_pcsrc", {6'd0, pcsrc}, 8'd1);
    zero = 1'b1;
    #1;
    chk("bne_nt_pcen", {7'd0, pcen}, 8'd0);
    tick();
    chk("bne_done", {4'd0, state}, 8'd0);
`else
    chk("bne_illegal", {7'd0, illegal}, 8'd1);
    tick();
    chk("bne_next_state", {4'd0, state}, 8'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
